// File: rtl/pbkdf2_ctrl.sv
// ---------------------------------------------------------------------------
// pbkdf2_ctrl
//
// Purpose:
//   Sequences one hmac_sha256 core to produce a single PBKDF2-HMAC-SHA256
//   output block T_i = U1 ^ U2 ^ ... ^ Uc, where
//     U1 = PRF(P, S || INT(i)) and Uj = PRF(P, U(j-1)).
//   The controller owns the iteration counter, the message formatting for
//   every PRF call and the XOR accumulation of the U values.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (shared with core)
//   v_i / r_o          job handshake (key_i, salt_i, salt_len_i, iter_i,
//                      blk_idx_i form the job payload)
//   v_o / r_i          result handshake (dk_o, err_o form the result payload)
//   busy_o             a job is in progress (ISSUE, WAIT or DONE)
//   hmac_key_o, hmac_msg_o, hmac_len_o, hmac_v_o / hmac_r_i
//                      request channel towards the hmac_sha256 core
//   hmac_prf_i, hmac_v_i / hmac_r_o
//                      response channel from the hmac_sha256 core
// ---------------------------------------------------------------------------
module pbkdf2_ctrl #(
  parameter int ITER_W     = 32,
  parameter int MAX_SALT_B = 60
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              v_i,
  output logic              r_o,
  input  logic [511:0]      key_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic [31:0]       blk_idx_i,
  output logic              v_o,
  input  logic              r_i,
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0]        MAX_SALT = 7'(MAX_SALT_B);
  localparam logic [ITER_W-1:0] CNT_ONE  = ITER_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [ITER_W-1:0]   r_cnt;
  logic [ITER_W-1:0]   r_cmax;
  logic [255:0]        r_acc;
  logic [255:0]        r_dk;
  logic [511:0]        r_key;
  logic [511:0]        r_msg;
  logic [5:0]          r_len;
  logic                r_err;

  logic                w_jobXfer;
  logic                w_resXfer;
  logic                w_doneXfer;
  logic                w_last;
  logic                w_saltBad;
  logic [8:0]          w_saltBits;
  logic [511:0]        w_saltMask;
  logic [511:0]        w_idxField;
  logic [511:0]        w_firstMsg;

  // Handshake strobes decode straight from the state register so that a
  // transfer can never be offered twice for the same request.
  assign r_o      = (r_state == IDLE) && rst_ni;
  assign hmac_v_o = (r_state == ISSUE);
  assign hmac_r_o = (r_state == WAIT);
  assign v_o      = (r_state == DONE);
  assign busy_o   = (r_state != IDLE);

  assign dk_o       = r_dk;
  assign err_o      = r_err;
  assign hmac_key_o = r_key;
  assign hmac_msg_o = r_msg;
  assign hmac_len_o = r_len;

  assign w_jobXfer  = (r_state == IDLE) && v_i;
  assign w_resXfer  = (r_state == WAIT) && hmac_v_i;
  assign w_doneXfer = (r_state == DONE) && r_i;
  assign w_last     = (r_cnt == r_cmax);
  assign w_saltBad  = ({1'b0, salt_len_i} > MAX_SALT);

  // First message: keep only the salt_len leading salt bytes, then drop the
  // big-endian block index directly behind them. Anything the host left in
  // the salt tail is masked off so it cannot corrupt INT(i).
  assign w_saltBits = {salt_len_i, 3'b000};
  assign w_saltMask = ~({512{1'b1}} >> w_saltBits);
  assign w_idxField = {blk_idx_i, 480'b0} >> w_saltBits;
  assign w_firstMsg = (salt_i & w_saltMask) | w_idxField;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode. An oversized salt skips the core entirely and goes
  // straight to DONE with the error flag raised.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (v_i) begin
          w_next = w_saltBad ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (hmac_r_i) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (hmac_v_i) begin
          w_next = w_last ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (r_i) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers. The counter compare is plain equality against the
  // latched limit, so an all-ones iteration count finishes before the
  // counter would ever need to wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_cmax <= '0;
      r_acc  <= '0;
      r_dk   <= '0;
      r_key  <= '0;
      r_msg  <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_jobXfer) begin
        r_key  <= key_i;
        r_cnt  <= CNT_ONE;
        r_cmax <= (iter_i == '0) ? CNT_ONE : iter_i;
        r_acc  <= '0;
        r_dk   <= '0;
        r_err  <= w_saltBad;
        if (!w_saltBad) begin
          r_msg <= w_firstMsg;
          r_len <= salt_len_i + 6'd4;
        end
      end
      if (w_resXfer) begin
        r_acc <= r_acc ^ hmac_prf_i;
        if (w_last) begin
          r_dk <= r_acc ^ hmac_prf_i;
        end else begin
          r_msg <= {hmac_prf_i, 256'b0};
          r_len <= 6'd32;
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
      if (w_doneXfer) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule
